// File: rtl/bmp_capture_ctrl.sv
// bmp_capture_ctrl: arms on start, skips frames, captures one frame as bottom-up BMP pixel writes and supplies header fields
module bmp_capture_ctrl #(
  parameter int HRES = 320,
  parameter int VRES = 240
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic [3:0]      i_skip,
  input  logic            i_vsync,
  input  logic            i_de,
  input  logic [23:0]     i_data,
  output logic            o_pix_we,
  output logic [23:0]     o_pix_data,
  output logic [15:0]     o_pix_x,
  output logic [15:0]     o_pix_y,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_err,
  output logic [1:0]      o_err_code,
  output logic [1:0]      o_pad,
  output logic [3:0][7:0] o_bfSize,
  output logic [3:0][7:0] o_biSizeImage,
  output logic [3:0][7:0] o_biWidth,
  output logic [3:0][7:0] o_biHeight
);
  typedef enum logic [2:0] {IDLE, ARM, CAPT, DONE, ERR} state_t;
  localparam int ROW_BYTES = ((HRES * 24 + 31) / 32) * 4;
  localparam int IMG_SIZE = ROW_BYTES * VRES;
  function automatic logic [31:0] bswap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction
  assign o_pad         = 2'(ROW_BYTES - HRES * 3);
  assign o_biSizeImage = bswap(32'(IMG_SIZE));
  assign o_bfSize      = bswap(32'(IMG_SIZE + 54));
  assign o_biWidth     = bswap(32'(HRES));
  assign o_biHeight    = bswap(32'(VRES));
  state_t      state_q, state_d;
  logic [3:0]  skip_q, skip_d;
  logic [15:0] x_q, x_d, line_q, line_d, pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [23:0] pix_data_q, pix_data_d;
  logic [1:0]  code_q, code_d;
  logic        vs_q, de_q, pix_we_q, pix_we_d, err_q, err_d, vs_rise, line_end;
  assign vs_rise    = i_vsync & ~vs_q;
  assign line_end   = ~i_de & de_q;
  assign o_pix_we   = pix_we_q;
  assign o_pix_data = pix_data_q;
  assign o_pix_x    = pix_x_q;
  assign o_pix_y    = pix_y_q;
  assign o_busy     = (state_q == ARM) || (state_q == CAPT);
  assign o_done     = state_q == DONE;
  assign o_err      = err_q;
  assign o_err_code = code_q;
  always_comb begin
    state_d    = state_q;
    skip_d     = skip_q;
    x_d        = x_q;
    line_d     = line_q;
    err_d      = err_q;
    code_d     = code_q;
    pix_we_d   = 1'b0;
    pix_data_d = pix_data_q;
    pix_x_d    = pix_x_q;
    pix_y_d    = pix_y_q;
    if (i_abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, ERR: if (i_start) begin
          state_d = ARM;
          skip_d  = i_skip;
          err_d   = 1'b0;
          code_d  = 2'd0;
        end
        ARM: if (vs_rise) begin
          state_d = (skip_q == 4'd0) ? CAPT : ARM;
          skip_d  = (skip_q == 4'd0) ? skip_q : skip_q - 4'd1;
          x_d     = 16'd0;
          line_d  = 16'd0;
        end
        CAPT: begin
          if (line_q == 16'(VRES)) begin
            state_d = DONE;
          end else if (vs_rise || (i_de && x_q == 16'(HRES)) || (line_end && x_q != 16'(HRES))) begin
            state_d = ERR;
            err_d   = 1'b1;
            code_d  = vs_rise ? 2'd3 : i_de ? 2'd1 : 2'd2;
          end else if (i_de) begin
            pix_we_d   = 1'b1;
            pix_data_d = i_data;
            pix_x_d    = x_q;
            pix_y_d    = 16'(VRES - 1) - line_q;
            x_d        = x_q + 16'd1;
          end else if (line_end) begin
            x_d    = 16'd0;
            line_d = line_q + 16'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      skip_q     <= '0;
      x_q        <= '0;
      line_q     <= '0;
      vs_q       <= 1'b0;
      de_q       <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= '0;
      pix_we_q   <= 1'b0;
      pix_data_q <= '0;
      pix_x_q    <= '0;
      pix_y_q    <= '0;
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      x_q        <= x_d;
      line_q     <= line_d;
      vs_q       <= i_vsync;
      de_q       <= i_de;
      err_q      <= err_d;
      code_q     <= code_d;
      pix_we_q   <= pix_we_d;
      pix_data_q <= pix_data_d;
      pix_x_q    <= pix_x_d;
      pix_y_q    <= pix_y_d;
    end
  end
endmodule

// File: tb/tb_bmp_capture_ctrl.sv
// tb_bmp_capture_ctrl: directed checks of a 7x2 capture instance plus header and first-pixel checks of a default instance
module tb_bmp_capture_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, i_start = 1'b0, i_abort = 1'b0, i_vsync = 1'b0, i_de = 1'b0;
  logic [3:0] i_skip = 4'd0;
  logic [23:0] i_data = 24'd0;
  logic o_pix_we, o_busy, o_done, o_err;
  logic [23:0] o_pix_data;
  logic [15:0] o_pix_x, o_pix_y;
  logic [1:0] o_err_code, o_pad;
  logic [3:0][7:0] o_bfSize, o_biSizeImage, o_biWidth, o_biHeight;
  logic d_we, d_busy, d_done, d_err;
  logic [23:0] d_data;
  logic [15:0] d_x, d_y;
  logic [1:0] d_code, d_pad;
  logic [3:0][7:0] d_bf, d_img, d_w, d_h;
  int n_tests = 0, n_fail = 0, wr_cnt = 0, done_cnt = 0, b;
  logic [15:0] wx [512], wy [512];
  logic [23:0] wd [512];
  logic def_seen = 1'b0;
  logic [15:0] def_x = 16'hFFFF, def_y = 16'hFFFF;
  always #5 clk = ~clk;
  bmp_capture_ctrl #(.HRES(7), .VRES(2)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort), .i_skip(i_skip),
    .i_vsync(i_vsync), .i_de(i_de), .i_data(i_data), .o_pix_we(o_pix_we), .o_pix_data(o_pix_data),
    .o_pix_x(o_pix_x), .o_pix_y(o_pix_y), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_err_code(o_err_code), .o_pad(o_pad), .o_bfSize(o_bfSize), .o_biSizeImage(o_biSizeImage),
    .o_biWidth(o_biWidth), .o_biHeight(o_biHeight)
  );
  bmp_capture_ctrl dut_def (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort), .i_skip(i_skip),
    .i_vsync(i_vsync), .i_de(i_de), .i_data(i_data), .o_pix_we(d_we), .o_pix_data(d_data),
    .o_pix_x(d_x), .o_pix_y(d_y), .o_busy(d_busy), .o_done(d_done), .o_err(d_err),
    .o_err_code(d_code), .o_pad(d_pad), .o_bfSize(d_bf), .o_biSizeImage(d_img),
    .o_biWidth(d_w), .o_biHeight(d_h)
  );
  always @(negedge clk) begin
    if (o_pix_we) begin
      wx[wr_cnt % 512] = o_pix_x;
      wy[wr_cnt % 512] = o_pix_y;
      wd[wr_cnt % 512] = o_pix_data;
      wr_cnt++;
    end
    if (o_done) done_cnt++;
    if (d_we && !def_seen) begin
      def_seen = 1'b1;
      def_x = d_x;
      def_y = d_y;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic start(input logic [3:0] s);
    i_skip = s;
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
  endtask
  task automatic vsync_pulse;
    i_vsync = 1'b1;
    tick;
    i_vsync = 1'b0;
    repeat (2) tick;
  endtask
  task automatic send_line(input int n, input int ln, input int gap);
    for (int i = 0; i < n; i++) begin
      i_de = 1'b1;
      i_data = {8'hA5, 8'(ln), 8'(i)};
      tick;
    end
    i_de = 1'b0;
    repeat (gap) tick;
  endtask
  task automatic frame;
    vsync_pulse;
    send_line(7, 0, 3);
    send_line(7, 1, 3);
  endtask
  initial begin
    repeat (2) tick;
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", {o_err, o_err_code}, 0);
    chk("rst_we", o_pix_we, 0);
    chk("pad_7x2", o_pad, 3);
    chk("img_7x2", o_biSizeImage, 32'h3000_0000);
    chk("bf_7x2", o_bfSize, 32'h6600_0000);
    chk("w_7x2", o_biWidth, 32'h0700_0000);
    chk("h_7x2", o_biHeight, 32'h0200_0000);
    chk("pad_def", d_pad, 0);
    chk("img_def", d_img, 32'h0084_0300);
    chk("bf_def", d_bf, 32'h3684_0300);
    chk("w_def", d_w, 32'h4001_0000);
    chk("h_def", d_h, 32'hF000_0000);
    rst_n = 1'b1;
    tick;
    // clean frame with exact done timing
    b = wr_cnt;
    start(0);
    chk("arm_busy", o_busy, 1);
    vsync_pulse;
    send_line(7, 0, 3);
    send_line(7, 1, 0);
    tick;
    chk("done_early", o_done, 0);
    tick;
    chk("done", o_done, 1);
    chk("done_busy", o_busy, 0);
    tick;
    chk("done_once", o_done, 0);
    chk("clean_wr", wr_cnt - b, 14);
    chk("first_x", wx[b], 0);
    chk("first_y", wy[b], 1);
    chk("last_x", wx[b + 13], 6);
    chk("last_y", wy[b + 13], 0);
    chk("last_d", wd[b + 13], 24'hA50106);
    chk("mid_d", wd[b + 7], 24'hA50100);
    chk("clean_done", done_cnt, 1);
    chk("clean_err", o_err, 0);
    chk("def_first_x", def_x, 0);
    chk("def_first_y", def_y, 239);
    // skip two frames
    b = wr_cnt;
    start(2);
    frame;
    frame;
    chk("skip_wr", wr_cnt - b, 0);
    chk("skip_busy", o_busy, 1);
    frame;
    chk("skip3_wr", wr_cnt - b, 14);
    chk("skip3_done", done_cnt, 2);
    chk("skip3_busy", o_busy, 0);
    // short line then long line
    b = wr_cnt;
    start(0);
    vsync_pulse;
    send_line(6, 0, 3);
    chk("short_err", {o_err, o_err_code}, 3'b110);
    chk("short_busy", o_busy, 0);
    send_line(7, 1, 3);
    chk("err_ignore_wr", wr_cnt - b, 6);
    start(0);
    chk("rearm_err", o_err, 0);
    chk("rearm_busy", o_busy, 1);
    b = wr_cnt;
    vsync_pulse;
    send_line(8, 0, 3);
    chk("long_err", {o_err, o_err_code}, 3'b101);
    chk("long_wr", wr_cnt - b, 7);
    chk("len_done", done_cnt, 2);
    // early vsync
    start(0);
    vsync_pulse;
    send_line(7, 0, 3);
    vsync_pulse;
    chk("fshort_err", {o_err, o_err_code}, 3'b111);
    chk("fshort_busy", o_busy, 0);
    // abort mid-line
    start(0);
    b = wr_cnt;
    vsync_pulse;
    send_line(7, 0, 3);
    send_line(3, 1, 0);
    i_de = 1'b1;
    i_abort = 1'b1;
    tick;
    i_abort = 1'b0;
    chk("abort_busy", o_busy, 0);
    chk("abort_we", o_pix_we, 0);
    send_line(3, 1, 3);
    chk("abort_wr", wr_cnt - b, 10);
    chk("abort_done", done_cnt, 2);
    chk("abort_err", o_err, 0);
    i_start = 1'b1;
    i_abort = 1'b1;
    tick;
    i_start = 1'b0;
    i_abort = 1'b0;
    chk("abort_over_start", o_busy, 0);
    // asynchronous reset mid-frame
    start(0);
    b = wr_cnt;
    vsync_pulse;
    send_line(3, 0, 0);
    chk("pre_rst_we", o_pix_we, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_we", o_pix_we, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_xy", {o_pix_x, o_pix_y}, 0);
    chk("arst_data", o_pix_data, 0);
    tick;
    rst_n = 1'b1;
    send_line(4, 0, 3);
    send_line(7, 1, 3);
    chk("arst_wr", wr_cnt - b, 2);
    chk("arst_done", done_cnt, 2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bmp_capture_ctrl.md
BMP_CAPTURE_CTRL -- requirements
Module: bmp_capture_ctrl

Interface
REQ-001 The block SHALL have parameter HRES, default 320, giving active pixels per line.
REQ-002 The block SHALL have parameter VRES, default 240, giving active lines per frame.
REQ-003 Port clk SHALL be an input, 1 bit wide, and is the single clock; all logic is clocked on its rising edge.
REQ-004 Port rst_n SHALL be an input, 1 bit wide, and is the asynchronous active-low reset.
REQ-005 Port i_start SHALL be an input, 1 bit wide, carrying a single-cycle capture request.
REQ-006 Port i_abort SHALL be an input, 1 bit wide, carrying a single-cycle cancel request.
REQ-007 Port i_skip SHALL be an input, 4 bits wide, giving the number of whole frames to skip before capture; it is latched on start.
REQ-008 Ports i_vsync and i_de SHALL be inputs, 1 bit wide each, carrying the timing of the pixel stream.
REQ-009 Port i_data SHALL be an input, 24 bits wide, carrying the pixel value and valid when i_de=1.
REQ-010 Port o_pix_we SHALL be an output, 1 bit wide, giving the pixel write strobe to the BMP writer.
REQ-011 Port o_pix_data SHALL be an output, 24 bits wide, carrying the captured pixel.
REQ-012 Ports o_pix_x and o_pix_y SHALL be outputs, 16 bits wide each; o_pix_x is the column and o_pix_y is the BMP row, counted bottom-up.
REQ-013 Port o_busy SHALL be an output, 1 bit wide, and is high while armed or capturing.
REQ-014 Port o_done SHALL be an output, 1 bit wide, carrying a one-cycle frame-complete pulse.
REQ-015 Port o_err SHALL be an output, 1 bit wide, and is a sticky error flag.
REQ-016 Port o_err_code SHALL be an output, 2 bits wide, with codes: 0 none, 1 line long, 2 line short, 3 frame short.
REQ-017 Port o_pad SHALL be an output, 2 bits wide, giving the row padding byte count.
REQ-018 Ports o_bfSize, o_biSizeImage, o_biWidth and o_biHeight SHALL be outputs, each 4x8 bits packed, carrying header fields; byte [3] is the first file byte, i.e. the value is byte-swapped to little-endian file order.

Function
REQ-019 The block SHALL implement the states IDLE, ARM, CAPT, DONE and ERR.
REQ-020 vsync rise SHALL be detected as i_vsync=1 with the previous sample 0; line end SHALL be detected as i_de=0 with the previous sample 1.
REQ-021 IDLE: on i_start the block SHALL latch i_skip into the skip counter, clear o_err/o_err_code, and go to ARM.
REQ-022 ARM: on vsync rise, the block SHALL go to CAPT if the skip counter is 0; otherwise it SHALL decrement the skip counter and stay in ARM.
REQ-023 CAPT: each cycle with i_de=1 and x<HRES SHALL register o_pix_we=1, o_pix_data=i_data, o_pix_x=x and o_pix_y=VRES-1-line, then increment x (one-cycle latency).
REQ-024 CAPT: if i_de=1 with x==HRES, the block SHALL raise err code 1, go to ERR, and not write that pixel.
REQ-025 CAPT: at line end with x<HRES, the block SHALL raise err code 2 and go to ERR; at line end with x==HRES it SHALL clear x and increment line.
REQ-026 CAPT: when line reaches VRES, the block SHALL go to DONE; o_done SHALL be high during DONE only, starting two rising edges after the edge sampling the final pixel; DONE SHALL go to IDLE next cycle.
REQ-027 CAPT: a vsync rise before line==VRES SHALL raise err code 3 and go to ERR.
REQ-028 ERR: o_err SHALL be held at 1; i_start SHALL clear the error and go to ARM; other inputs SHALL be ignored.
REQ-029 i_abort in any state SHALL force IDLE at the next edge with no o_done and no error; i_abort SHALL take priority over i_start and over error detection.
REQ-030 i_start outside IDLE/ERR SHALL be ignored.
REQ-031 o_pix_we SHALL be 0 in every cycle not immediately following an accepted CAPT pixel.
REQ-032 o_busy SHALL be 1 exactly when the state is ARM or CAPT.
REQ-033 The header SHALL be constant-derived from the parameters: row_bytes = ((HRES*24+31)/32)*4; o_pad = row_bytes-HRES*3; biSizeImage = row_bytes*VRES; bfSize = biSizeImage+54; biWidth = HRES; biHeight = VRES (positive, bottom-up); all held in byte-swapped form.
REQ-034 All arithmetic SHALL be unsigned; the x and line counters SHALL be 16 bits wide and never wrap, bounded by the checks above.

Reset
REQ-035 While rst_n=0, asynchronously: state SHALL be IDLE, all counters 0, and o_pix_we, o_pix_data, o_pix_x, o_pix_y, o_busy, o_done, o_err and o_err_code SHALL be 0; header outputs and o_pad SHALL stay at their constants.
REQ-036 Reset asserted mid-capture SHALL discard the frame, with no o_done afterwards until a new i_start.

Verification
REQ-037 Default parameters, skip=0, start before vsync, clean frame -> 76800 o_pix_we pulses, first pixel x=0 y=239, last x=319 y=0, one o_done, o_err=0, o_bfSize=32'h3684_0300, o_biSizeImage=32'h0084_0300, o_biWidth=32'h4001_0000, o_biHeight=32'hF000_0000, o_pad=0.
REQ-038 skip=2 -> no o_pix_we during the first two frames after start; the third frame is captured fully, then o_done.
REQ-039 A 319-pixel line in CAPT -> err code 2 at that line end; a 321-pixel line -> err code 1 on the 321st pixel with no write; no o_done in either case; i_start re-arms and clears o_err.
REQ-040 vsync rise after 100 lines -> err code 3, o_busy=0, o_err=1.
REQ-041 i_abort at line 50 -> IDLE next cycle, o_busy=0, no further o_pix_we, no o_done; rst_n pulse mid-frame -> all outputs 0 immediately.
REQ-042 HRES=7, VRES=2 -> o_pad=3, o_biSizeImage=32'h3000_0000 (48), o_bfSize=32'h6600_0000 (102).
